// File: rtl/swc_rr_page_allocator.sv
// Multiport page allocator: round-robin arbitration over alloc/free/force-free/set-usecount
// requests, backed by a free-list FIFO and a per-page use-count RAM.
module swc_rr_page_allocator #(
  parameter int unsigned g_num_ports       = 7,
  parameter int unsigned g_page_num        = 1024,
  parameter int unsigned g_page_addr_width = 10,
  parameter int unsigned g_usecount_width  = 4,
  parameter int unsigned g_low_watermark   = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [g_num_ports-1:0]                    alloc_i,
  input  logic [g_num_ports-1:0]                    free_i,
  input  logic [g_num_ports-1:0]                    force_free_i,
  input  logic [g_num_ports-1:0]                    set_usecnt_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]  pgaddr_free_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]  pgaddr_force_free_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]  pgaddr_usecnt_i,
  input  logic [g_num_ports*g_usecount_width-1:0]   usecnt_i,
  output logic [g_num_ports-1:0]                    done_o,
  output logic [g_num_ports*g_page_addr_width-1:0]  pgaddr_alloc_o,
  output logic [g_page_addr_width:0]                free_pages_o,
  output logic                                      nomem_o,
  output logic                                      low_wm_o,
  output logic                                      init_done_o,
  output logic                                      err_o
);

  localparam int unsigned P  = g_num_ports;
  localparam int unsigned A  = g_page_addr_width;
  localparam int unsigned U  = g_usecount_width;
  localparam int unsigned N  = g_page_num;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_UPDATE} state_t;
  typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_FORCE, OP_SET} op_t;

  state_t        state;
  op_t           op;
  logic [PW-1:0] port, last, grant;
  logic          grant_valid;
  logic [A-1:0]  page, init_k, rd_ptr, wr_ptr;
  logic [U-1:0]  cnt, cur;
  logic [A:0]    free_nxt;

  logic [A-1:0]  fifo [N];
  logic [U-1:0]  ucnt [N];
  logic [A-1:0]  alloc_pg [P];

  logic [P-1:0]  elig;
  logic [A-1:0]  free_pg [P];
  logic [A-1:0]  force_pg [P];
  logic [A-1:0]  set_pg [P];
  logic [U-1:0]  cnt_in [P];

  logic          push, reject, ram_we, fifo_we;
  logic [A-1:0]  ram_addr, fifo_addr, fifo_data;
  logic [U-1:0]  ram_data;

  // An alloc request is held back while memory is empty so it cannot starve other ports.
  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      free_pg[i]  = pgaddr_free_i[i*A +: A];
      force_pg[i] = pgaddr_force_free_i[i*A +: A];
      set_pg[i]   = pgaddr_usecnt_i[i*A +: A];
      cnt_in[i]   = usecnt_i[i*U +: U];
      elig[i]     = (alloc_i[i] | free_i[i] | force_free_i[i] | set_usecnt_i[i])
                    & ~done_o[i] & ~(alloc_i[i] & (free_pages_o == '0));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      pgaddr_alloc_o[i*A +: A] = alloc_pg[i];
    end
  end

  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant       = last;
    cand        = 0;
    for (int unsigned off = 1; off <= P; off++) begin
      cand = (32'(last) + off) % P;
      if (!grant_valid && elig[PW'(cand)]) begin
        grant_valid = 1'b1;
        grant       = PW'(cand);
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = page;
    ram_data  = '0;
    fifo_we   = 1'b0;
    fifo_addr = wr_ptr;
    fifo_data = page;
    push      = 1'b0;
    reject    = 1'b0;
    free_nxt  = free_pages_o;
    case (state)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = init_k;
        fifo_we   = 1'b1;
        fifo_addr = init_k;
        fifo_data = init_k;
        free_nxt  = {1'b0, init_k} + (A+1)'(1);
      end
      S_UPDATE: begin
        case (op)
          OP_ALLOC: begin
            ram_we   = 1'b1;
            ram_data = (cnt == '0) ? U'(1) : cnt;
            free_nxt = free_pages_o - (A+1)'(1);
          end
          OP_FREE: begin
            if (cur == '0) reject = 1'b1;
            else begin
              ram_we   = 1'b1;
              ram_data = cur - U'(1);
              push     = (cur == U'(1));
            end
          end
          OP_FORCE: begin
            if (cur == '0) reject = 1'b1;
            else begin
              ram_we = 1'b1;
              push   = 1'b1;
            end
          end
          OP_SET: begin
            if (cnt == '0) reject = 1'b1;
            else begin
              ram_we   = 1'b1;
              ram_data = cnt;
            end
          end
        endcase
        if (push) begin
          fifo_we  = 1'b1;
          free_nxt = free_pages_o + (A+1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we && !rst_i) ucnt[ram_addr] <= ram_data;
    if (fifo_we && !rst_i) fifo[fifo_addr] <= fifo_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_INIT;
      op           <= OP_ALLOC;
      port         <= '0;
      last         <= PW'(P-1);
      page         <= '0;
      cnt          <= '0;
      cur          <= '0;
      init_k       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      done_o       <= '0;
      err_o        <= 1'b0;
      init_done_o  <= 1'b0;
      free_pages_o <= '0;
      nomem_o      <= 1'b1;
      low_wm_o     <= 1'b1;
      for (int unsigned i = 0; i < P; i++) alloc_pg[i] <= '0;
    end else begin
      done_o       <= '0;
      err_o        <= 1'b0;
      free_pages_o <= free_nxt;
      nomem_o      <= (free_nxt == '0);
      low_wm_o     <= (32'(free_nxt) < g_low_watermark);
      case (state)
        S_INIT: begin
          init_k <= init_k + A'(1);
          if (init_k == A'(N-1)) begin
            state       <= S_IDLE;
            init_done_o <= 1'b1;
          end
        end
        S_IDLE: begin
          if (grant_valid) begin
            last  <= grant;
            port  <= grant;
            state <= S_READ;
            if (alloc_i[grant]) begin
              op  <= OP_ALLOC;
              cnt <= cnt_in[grant];
            end else if (free_i[grant]) begin
              op   <= OP_FREE;
              page <= free_pg[grant];
            end else if (force_free_i[grant]) begin
              op   <= OP_FORCE;
              page <= force_pg[grant];
            end else begin
              op   <= OP_SET;
              page <= set_pg[grant];
              cnt  <= cnt_in[grant];
            end
          end
        end
        S_READ: begin
          cur <= ucnt[page];
          // For alloc the page operand is replaced by the free-list head.
          if (op == OP_ALLOC) begin
            page   <= fifo[rd_ptr];
            rd_ptr <= (rd_ptr == A'(N-1)) ? '0 : rd_ptr + A'(1);
          end
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          done_o[port] <= 1'b1;
          err_o        <= reject;
          if (op == OP_ALLOC) alloc_pg[port] <= page;
          if (push) wr_ptr <= (wr_ptr == A'(N-1)) ? '0 : wr_ptr + A'(1);
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swc_rr_page_allocator.sv
// Bench for swc_rr_page_allocator: transaction-level model (free-list queue, use-count
// array) checked every cycle, plus directed scenarios with literal expectations.
module tb_swc_rr_page_allocator;

  localparam int P = 7, A = 10, U = 4, N = 1024, LOW = 16;
  localparam int OP_ALLOC = 0, OP_FREE = 1, OP_FORCE = 2, OP_SET = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [P-1:0]     alloc, fr, ff, su;
  logic [P*A-1:0]   pg_free, pg_ff, pg_su;
  logic [P*U-1:0]   ucin;
  logic [P-1:0]     done;
  logic [P*A-1:0]   pg_alloc;
  logic [A:0]       free_pages;
  logic             nomem, low_wm, init_done, err;

  always #5 clk = ~clk;

  swc_rr_page_allocator #(
    .g_num_ports(P), .g_page_num(N), .g_page_addr_width(A),
    .g_usecount_width(U), .g_low_watermark(LOW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_i(alloc), .free_i(fr), .force_free_i(ff), .set_usecnt_i(su),
    .pgaddr_free_i(pg_free), .pgaddr_force_free_i(pg_ff), .pgaddr_usecnt_i(pg_su),
    .usecnt_i(ucin),
    .done_o(done), .pgaddr_alloc_o(pg_alloc), .free_pages_o(free_pages),
    .nomem_o(nomem), .low_wm_o(low_wm), .init_done_o(init_done), .err_o(err)
  );

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned fl[$];
  int unsigned uc[N];
  logic [P-1:0] m_done;
  bit           m_err, m_init, m_valid = 0;
  int unsigned  m_initk, m_last, m_port, m_page, m_cnt;
  int           m_busy, m_op;
  int unsigned  m_alloc[P];

  task automatic model_step();
    logic [P-1:0] prev;
    bit found;
    int unsigned a, c;
    if (rst) begin
      fl.delete();
      m_done = '0; m_err = 0; m_init = 0; m_initk = 0;
      m_last = P - 1; m_busy = 0;
      for (int i = 0; i < P; i++) m_alloc[i] = 0;
    end else begin
      prev = m_done;
      m_done = '0;
      m_err = 0;
      if (!m_init) begin
        fl.push_back(m_initk);
        uc[m_initk] = 0;
        m_initk++;
        if (m_initk == N) m_init = 1;
      end else if (m_busy == 0) begin
        found = 0;
        for (int off = 1; off <= P; off++) begin
          c = (m_last + off) % P;
          if (!found && (alloc[c] | fr[c] | ff[c] | su[c]) && !prev[c] &&
              !(alloc[c] && fl.size() == 0)) begin
            found = 1;
            m_last = c; m_port = c; m_busy = 1;
            if (alloc[c]) begin
              m_op = OP_ALLOC; m_cnt = ucin[c*U +: U];
            end else if (fr[c]) begin
              m_op = OP_FREE; m_page = pg_free[c*A +: A];
            end else if (ff[c]) begin
              m_op = OP_FORCE; m_page = pg_ff[c*A +: A];
            end else begin
              m_op = OP_SET; m_page = pg_su[c*A +: A]; m_cnt = ucin[c*U +: U];
            end
          end
        end
      end else if (m_busy == 1) begin
        m_busy = 2;
      end else begin
        case (m_op)
          OP_ALLOC: begin
            a = fl.pop_front();
            uc[a] = (m_cnt == 0) ? 1 : m_cnt;
            m_alloc[m_port] = a;
          end
          OP_FREE: begin
            if (uc[m_page] == 0) m_err = 1;
            else begin
              uc[m_page]--;
              if (uc[m_page] == 0) fl.push_back(m_page);
            end
          end
          OP_FORCE: begin
            if (uc[m_page] == 0) m_err = 1;
            else begin
              uc[m_page] = 0;
              fl.push_back(m_page);
            end
          end
          default: begin
            if (m_cnt == 0) m_err = 1;
            else uc[m_page] = m_cnt;
          end
        endcase
        m_done[m_port] = 1'b1;
        m_busy = 0;
      end
    end
    m_valid = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("done", done, m_done);
      check("err", err, m_err);
      check("init_done", init_done, m_init);
      check("free_pages", free_pages, fl.size());
      check("nomem", nomem, fl.size() == 0);
      check("low_wm", low_wm, fl.size() < LOW);
      for (int p = 0; p < P; p++)
        check($sformatf("pgaddr_alloc[%0d]", p), pg_alloc[p*A +: A], m_alloc[p]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int p);
    alloc[p] = 0; fr[p] = 0; ff[p] = 0; su[p] = 0;
  endtask

  task automatic req(input int p, input int op, input int page, input int cnt);
    clr(p);
    case (op)
      OP_ALLOC: alloc[p] = 1;
      OP_FREE:  fr[p] = 1;
      OP_FORCE: ff[p] = 1;
      default:  su[p] = 1;
    endcase
    pg_free[p*A +: A] = A'(page);
    pg_ff[p*A +: A]   = A'(page);
    pg_su[p*A +: A]   = A'(page);
    ucin[p*U +: U]    = U'(cnt);
  endtask

  task automatic wait_done(input int p, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = done[p];
    end
  endtask

  task automatic do_op(input int p, input int op, input int page, input int cnt, input string tag);
    bit ok;
    req(p, op, page, cnt);
    wait_done(p, ok);
    check({tag, "_timeout"}, ok, 1);
    clr(p);
  endtask

  task automatic wait_init(input string tag, output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      tick();
      n++;
    end
  endtask

  int  owner_of[N];
  bit  active[P];
  int  aop[P], apage[P];

  task automatic rand_issue(input int p);
    int s, pick, r;
    pick = -1;
    s = $urandom_range(0, N - 1);
    for (int i = 0; i < N && pick < 0; i++)
      if (owner_of[(s + i) % N] == p) pick = (s + i) % N;
    r = $urandom_range(0, 99);
    if (pick < 0 || r < 35) begin
      aop[p] = OP_ALLOC; apage[p] = 0;
      req(p, OP_ALLOC, 0, $urandom_range(0, 3));
    end else begin
      aop[p] = (r < 70) ? OP_FREE : (r < 85) ? OP_FORCE : OP_SET;
      apage[p] = pick;
      req(p, aop[p], pick, $urandom_range(0, 15));
    end
    active[p] = 1;
  endtask

  task automatic rand_complete(input int p);
    if (aop[p] == OP_ALLOC) owner_of[m_alloc[p]] = p;
    else if (aop[p] != OP_SET && uc[apage[p]] == 0) owner_of[apage[p]] = -1;
    clr(p);
    active[p] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, k, lastc, others, rem, low_at, nomem_at, busy_any;
    int exp_ord[6];
    bit ok;
    logic [P-1:0] e;

    rst = 1;
    alloc = '0; fr = '0; ff = '0; su = '0;
    pg_free = '0; pg_ff = '0; pg_su = '0; ucin = '0;
    for (int i = 0; i < N; i++) owner_of[i] = -1;
    for (int i = 0; i < P; i++) active[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_free", free_pages, 0);
    check("rst_nomem", nomem, 1);
    check("rst_low_wm", low_wm, 1);
    check("rst_init_done", init_done, 0);
    check("rst_done", done, 0);
    rst = 0;

    wait_init("init", n);
    check("init_latency", n, N);
    check("init_free", free_pages, N);
    check("init_low_wm", low_wm, 0);

    // round trip
    do_op(0, OP_ALLOC, 0, 2, "rt_alloc");
    check("rt_page", pg_alloc[0 +: A], 0);
    check("rt_free_after_alloc", free_pages, N - 1);
    do_op(0, OP_FREE, 0, 0, "rt_free1");
    check("rt_free1_count", free_pages, N - 1);
    check("rt_free1_err", err, 0);
    do_op(0, OP_FREE, 0, 0, "rt_free2");
    check("rt_free2_count", free_pages, N);
    check("rt_free2_err", err, 0);

    // round-robin among held allocs on ports 1, 3, 5
    exp_ord = '{1, 3, 5, 1, 3, 5};
    req(1, OP_ALLOC, 0, 1); req(3, OP_ALLOC, 0, 1); req(5, OP_ALLOC, 0, 1);
    k = 0; lastc = -1;
    for (int i = 0; i < 100 && k < 6; i++) begin
      tick();
      if (done != '0) begin
        e = '0;
        e[exp_ord[k]] = 1'b1;
        check("rr_order", done, e);
        check("rr_page", pg_alloc[exp_ord[k]*A +: A], k + 1);
        if (lastc >= 0) check("rr_spacing", i - lastc, 3);
        lastc = i;
        k++;
      end
    end
    check("rr_count", k, 6);
    req(6, OP_SET, 1, 5);
    others = 0; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (done[6]) ok = 1;
      else if (done != '0) others++;
    end
    check("set_done", ok, 1);
    check("set_wait_bounded", others <= P - 1, 1);
    clr(6); clr(1); clr(3); clr(5);
    repeat (4) tick();

    // exhaustion
    rem = free_pages;
    low_at = -1; nomem_at = -1;
    for (int j = 0; j < rem; j++) begin
      do_op(0, OP_ALLOC, 0, 2, "ex_alloc");
      if (low_wm && low_at < 0) low_at = j;
      if (nomem && nomem_at < 0) nomem_at = j;
    end
    check("ex_low_wm_rise", low_at, rem - LOW);
    check("ex_nomem_rise", nomem_at, rem - 1);
    check("ex_last_page", pg_alloc[0 +: A], 0);
    check("ex_free_zero", free_pages, 0);

    req(0, OP_ALLOC, 0, 2);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("ex_pending_no_done", done[0], 0);
    end
    do_op(1, OP_FORCE, 3, 0, "ex_force");
    check("ex_force_err", err, 0);
    wait_done(0, ok);
    check("ex_pending_done", ok, 1);
    check("ex_pending_page", pg_alloc[0 +: A], 3);
    check("ex_pending_free", free_pages, 0);
    clr(0);

    // error cases
    do_op(1, OP_FORCE, 3, 0, "er_ff3");
    check("er_ff3_err", err, 0);
    check("er_ff3_free", free_pages, 1);
    do_op(1, OP_FREE, 3, 0, "er_dblfree");
    check("er_dblfree_err", err, 1);
    check("er_dblfree_free", free_pages, 1);
    do_op(2, OP_SET, 0, 0, "er_set0");
    check("er_set0_err", err, 1);
    do_op(2, OP_FREE, 0, 0, "er_free_after_set0");
    check("er_free_after_set0_err", err, 0);
    check("er_free_after_set0_free", free_pages, 1);
    do_op(2, OP_SET, 0, 3, "er_set3");
    check("er_set3_err", err, 0);
    do_op(2, OP_FORCE, 0, 0, "er_ff_cnt3");
    check("er_ff_cnt3_err", err, 0);
    check("er_ff_cnt3_free", free_pages, 2);
    do_op(2, OP_FORCE, 0, 0, "er_ff_again");
    check("er_ff_again_err", err, 1);
    check("er_ff_again_free", free_pages, 2);
    do_op(3, OP_ALLOC, 0, 1, "er_realloc_a");
    check("er_realloc_a_page", pg_alloc[3*A +: A], 3);
    do_op(3, OP_ALLOC, 0, 1, "er_realloc_b");
    check("er_realloc_b_page", pg_alloc[3*A +: A], 0);
    check("er_realloc_free", free_pages, 0);

    // reset during READ of an alloc
    do_op(4, OP_FORCE, 3, 0, "rs_prep");
    req(0, OP_ALLOC, 0, 1);
    for (int i = 0; i < 50 && m_busy != 1; i++) tick();
    check("rs_grant_seen", m_busy, 1);
    rst = 1;
    for (int p = 0; p < P; p++) clr(p);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rs_no_done", done, 0);
    end
    check("rs_free", free_pages, 0);
    check("rs_nomem", nomem, 1);
    check("rs_low_wm", low_wm, 1);
    check("rs_init_done", init_done, 0);
    check("rs_pg_alloc", pg_alloc, 0);
    rst = 0;
    for (int i = 0; i < N; i++) owner_of[i] = -1;
    wait_init("rs_init", n);
    check("rs_init_latency", n, N);
    check("rs_final_free", free_pages, N);

    // randomized traffic with per-port page ownership
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int p = 0; p < P; p++) begin
        if (active[p] && m_done[p]) rand_complete(p);
        if (!active[p] && $urandom_range(0, 3) == 0) rand_issue(p);
      end
    end
    busy_any = 1;
    for (int cyc = 0; cyc < 400 && busy_any != 0; cyc++) begin
      tick();
      busy_any = 0;
      for (int p = 0; p < P; p++) begin
        if (active[p] && m_done[p]) rand_complete(p);
        if (active[p]) busy_any++;
      end
    end
    check("rand_drain", busy_any, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
